sync_fifo_gen: RTL and testbench

Single-clock, parametrised FIFO; the next generation of the team's FIFO family for same-domain buffering. Supports any integer depth (non-power-of-2), an occupancy count, programmable almost-full and almost-empty thresholds, and standard or first-word-fall-through (FWFT) read mode. Reuses the existing dual_port_ram as storage; both RAM ports are clocked by clk.

---
 rtl/sync_fifo_pkg.sv | 20 ++
 rtl/dual_port_ram.sv | 37 +++
 rtl/sync_fifo_gen.sv | 146 ++++++++++++++
 tb/tb_sync_fifo_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
//   Shared constants and helpers for the sync_fifo_gen family.
//   FWFT_OFF / FWFT_ON : read-mode selectors for the FWFT parameter.
//   cnt_width(depth)   : width of a 0..depth occupancy counter.
//   ptr_next(ptr,depth): pointer increment with explicit wrap at depth-1.
package sync_fifo_pkg;

    localparam int unsigned FWFT_OFF = 0;
    localparam int unsigned FWFT_ON  = 1;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Wrap is explicit so non-power-of-two depths work.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/dual_port_ram.sv
// dual_port_ram
//   Simple dual-port storage: synchronous write port, combinational read port.
//   Ports:
//     wr_clk, wr_rst      write clock; writes are ignored while wr_rst is high
//     wr_en, wr_addr, wr_data
//     rd_clk              read-side clock (read port is combinational)
//     rd_addr, rd_data    combinational read
module dual_port_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_clk,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // rd_clk exists for interface compatibility with registered-read variants.
    logic w_unused_rd_clk;
    assign w_unused_rd_clk = rd_clk;

    always_ff @(posedge wr_clk) begin
        if (!wr_rst && wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/sync_fifo_gen.sv
// sync_fifo_gen
//   Single-clock FIFO of any depth >= 2 with occupancy count, programmable
//   almost-full/almost-empty thresholds and standard or FWFT read mode.
//   Storage is dual_port_ram; both RAM clocks are clk.
//   Build option: SYNC_FIFO_STICKY_ERR_EN makes overflow/underflow sticky
//   until rst (default: one-cycle pulses).
//   Ports:
//     clk, rst                   clock, synchronous active-high reset
//     wr_en, wr_data             write request / word
//     full, almost_full          count == DEPTH / count >= AFULL_THRESH
//     overflow                   write rejected
//     rd_en                      read request (FWFT: pop presented word)
//     rd_data, rd_valid          read word / valid
//     empty, almost_empty        nothing readable / count <= AEMPTY_THRESH
//     underflow                  read rejected
//     count                      words held, 0..DEPTH
module sync_fifo_gen
    import sync_fifo_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH    = 8,
    parameter int unsigned  DEPTH         = 10,
    parameter int unsigned  FWFT          = 0,
    parameter int unsigned  AFULL_THRESH  = 8,
    parameter int unsigned  AEMPTY_THRESH = 2,
    localparam int unsigned CNT_W         = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  underflow,
    output logic [CNT_W-1:0]      count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_valid;      // FWFT: output-register valid; standard: read-data pulse
    logic                  r_overflow;
    logic                  r_underflow;

    logic [DATA_WIDTH-1:0] w_ram_rd_data;
    logic [CNT_W-1:0]      w_ram_cnt;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_load;
    logic                  w_rd_adv;

    always_comb begin
        w_full    = (r_count == CNT_W'(DEPTH));
        w_empty   = (FWFT == FWFT_ON) ? !r_valid : (r_count == '0);
        w_wr_acc  = wr_en && !w_full;
        w_rd_acc  = rd_en && !w_empty;
        // In FWFT mode count includes the staged word; the RAM holds the rest.
        w_ram_cnt = r_count - CNT_W'(r_valid);
        w_load    = (!r_valid || w_rd_acc) && (w_ram_cnt != '0);
        w_rd_adv  = (FWFT == FWFT_ON) ? w_load : w_rd_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_data   <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= PTR_W'(ptr_next(32'(r_wr_ptr), DEPTH));
            end
            if (w_rd_adv) begin
                r_rd_ptr <= PTR_W'(ptr_next(32'(r_rd_ptr), DEPTH));
            end

            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (FWFT == FWFT_ON) begin
                // Refill the output register on the same edge it is popped.
                if (w_load) begin
                    r_rd_data <= w_ram_rd_data;
                    r_valid   <= 1'b1;
                end else if (w_rd_acc) begin
                    r_valid   <= 1'b0;
                end
            end else begin
                r_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_rd_data <= w_ram_rd_data;
                end
            end

`ifdef SYNC_FIFO_STICKY_ERR_EN
            r_overflow  <= r_overflow  || (wr_en && w_full);
            r_underflow <= r_underflow || (rd_en && w_empty);
`else
            r_overflow  <= wr_en && w_full;
            r_underflow <= rd_en && w_empty;
`endif
        end
    end

    dual_port_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (PTR_W)
    ) u_ram (
        .wr_clk  (clk),
        .wr_rst  (rst),
        .wr_en   (w_wr_acc),
        .wr_addr (r_wr_ptr),
        .wr_data (wr_data),
        .rd_clk  (clk),
        .rd_addr (r_rd_ptr),
        .rd_data (w_ram_rd_data)
    );

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (32'(r_count) >= AFULL_THRESH);
    assign almost_empty = (32'(r_count) <= AEMPTY_THRESH);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign rd_data      = r_rd_data;
    assign rd_valid     = r_valid;
    assign count        = r_count;

endmodule

// File: tb/tb_sync_fifo_gen.sv
// tb_sync_fifo_gen
//   Drives a standard-mode and an FWFT-mode sync_fifo_gen (DEPTH=10) with the
//   same inputs and checks both against queue-based reference models.
//   FWFT model: a word is presented once it was written on an earlier edge
//   than the most recent one and is at the head of the queue.
module tb_sync_fifo_gen;

    localparam int unsigned D = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wr_data;

    logic       s_full, s_afull, s_ovf, s_valid, s_empty, s_aempty, s_unf;
    logic [7:0] s_data;
    logic [3:0] s_count;
    logic       f_full, f_afull, f_ovf, f_valid, f_empty, f_aempty, f_unf;
    logic [7:0] f_data;
    logic [3:0] f_count;

    sync_fifo_gen #(
        .DATA_WIDTH(8), .DEPTH(D), .FWFT(0), .AFULL_THRESH(8), .AEMPTY_THRESH(2)
    ) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(s_full), .almost_full(s_afull), .overflow(s_ovf),
        .rd_en(rd_en), .rd_data(s_data), .rd_valid(s_valid),
        .empty(s_empty), .almost_empty(s_aempty), .underflow(s_unf), .count(s_count)
    );

    sync_fifo_gen #(
        .DATA_WIDTH(8), .DEPTH(D), .FWFT(1), .AFULL_THRESH(8), .AEMPTY_THRESH(2)
    ) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(f_full), .almost_full(f_afull), .overflow(f_ovf),
        .rd_en(rd_en), .rd_data(f_data), .rd_valid(f_valid),
        .empty(f_empty), .almost_empty(f_aempty), .underflow(f_unf), .count(f_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        int unsigned we;
    } fent_t;

    logic [7:0]  qs[$];
    fent_t       qf[$];
    int unsigned ecnt = 0;
    logic [7:0]  es_data = '0;
    logic        es_valid = 1'b0;
    logic        es_ovf = 1'b0, es_unf = 1'b0, ef_ovf = 1'b0, ef_unf = 1'b0;
    int          n_assert = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit fvis();
        return (qf.size() > 0) && (qf[0].we < ecnt);
    endfunction

    task automatic check_all();
        chk("s_count",  32'(s_count),  qs.size());
        chk("s_full",   32'(s_full),   32'(qs.size() == D));
        chk("s_afull",  32'(s_afull),  32'(qs.size() >= 8));
        chk("s_empty",  32'(s_empty),  32'(qs.size() == 0));
        chk("s_aempty", 32'(s_aempty), 32'(qs.size() <= 2));
        chk("s_valid",  32'(s_valid),  32'(es_valid));
        chk("s_data",   32'(s_data),   32'(es_data));
        chk("s_ovf",    32'(s_ovf),    32'(es_ovf));
        chk("s_unf",    32'(s_unf),    32'(es_unf));
        chk("f_count",  32'(f_count),  qf.size());
        chk("f_full",   32'(f_full),   32'(qf.size() == D));
        chk("f_afull",  32'(f_afull),  32'(qf.size() >= 8));
        chk("f_aempty", 32'(f_aempty), 32'(qf.size() <= 2));
        chk("f_empty",  32'(f_empty),  32'(!fvis()));
        chk("f_valid",  32'(f_valid),  32'(fvis()));
        if (fvis()) chk("f_data", 32'(f_data), 32'(qf[0].d));
        chk("f_ovf",    32'(f_ovf),    32'(ef_ovf));
        chk("f_unf",    32'(f_unf),    32'(ef_unf));
    endtask

    // One clock edge: update both models from the pre-edge inputs, then check.
    task automatic tick();
        bit s_fl, s_em, f_fl, f_vs;
        @(posedge clk);
        s_fl = (qs.size() == D);
        s_em = (qs.size() == 0);
        f_fl = (qf.size() == D);
        f_vs = fvis();
        ecnt++;
        if (rst) begin
            qs.delete();
            qf.delete();
            es_data  = '0;
            es_valid = 1'b0;
            es_ovf = 1'b0; es_unf = 1'b0; ef_ovf = 1'b0; ef_unf = 1'b0;
        end else begin
            es_valid = rd_en && !s_em;
            if (es_valid) es_data = qs.pop_front();
            if (wr_en && !s_fl) qs.push_back(wr_data);
            if (rd_en && f_vs) qf.delete(0);
            if (wr_en && !f_fl) qf.push_back('{d: wr_data, we: ecnt});
`ifdef SYNC_FIFO_STICKY_ERR_EN
            es_ovf = es_ovf | (wr_en && s_fl);
            es_unf = es_unf | (rd_en && s_em);
            ef_ovf = ef_ovf | (wr_en && f_fl);
            ef_unf = ef_unf | (rd_en && !f_vs);
`else
            es_ovf = wr_en && s_fl;
            es_unf = rd_en && s_em;
            ef_ovf = wr_en && f_fl;
            ef_unf = rd_en && !f_vs;
`endif
        end
        #1;
        check_all();
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic r);
        wr_en = w; wr_data = d; rd_en = r;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_s_empty", 32'(s_empty), 32'd1);
        chk("rst_s_count", 32'(s_count), 32'd0);
        chk("rst_f_data",  32'(f_data),  32'd0);

        // 1: fill, then one write too many
        for (int unsigned i = 1; i <= D; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            tick();
            if (i == 8) chk("t1_afull_at8", 32'(s_afull), 32'd1);
        end
        chk("t1_full",  32'(s_full),  32'd1);
        chk("t1_count", 32'(s_count), 32'd10);
        drive(1'b1, 8'hEE, 1'b0);
        tick();
        chk("t1_ovf", 32'(s_ovf), 32'd1);
        drive(1'b0, 8'h00, 1'b0);
        tick();

        // 2: drain, then one read too many
        for (int unsigned i = 1; i <= D; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            tick();
            chk("t2_order", 32'(s_data), i);
        end
        tick();
        chk("t2_unf",   32'(s_unf),   32'd1);
        chk("t2_noval", 32'(s_valid), 32'd0);
        drive(1'b0, 8'h00, 1'b0);
        tick();

        // 3: pointer wrap with occupancy held between 3 and 7
        for (int unsigned i = 0; i < 5; i++) begin
            drive(1'b1, 8'($urandom), 1'b0);
            tick();
        end
        for (int unsigned i = 0; i < 25; i++) begin
            drive((qs.size() < 7) ? 1'($urandom) : 1'b0, 8'($urandom),
                  (qs.size() > 3) ? 1'($urandom) : 1'b0);
            tick();
        end

        // 4: simultaneous read/write at full and at empty
        do_reset();
        for (int unsigned i = 0; i < D; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b0);
            tick();
        end
        drive(1'b1, 8'h77, 1'b1);
        tick();
        chk("t4_full_cnt", 32'(s_count), 32'd9);
        chk("t4_full_ovf", 32'(s_ovf),   32'd1);
        do_reset();
        drive(1'b1, 8'h33, 1'b1);
        tick();
        chk("t4_emp_cnt", 32'(s_count), 32'd1);
        chk("t4_emp_unf", 32'(s_unf),   32'd1);

        // 5: FWFT latency and back-to-back pops
        do_reset();
        drive(1'b1, 8'hA5, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("t5_lat1", 32'(f_valid), 32'd0);
        tick();
        chk("t5_lat2", 32'(f_valid), 32'd1);
        chk("t5_data", 32'(f_data),  32'hA5);
        do_reset();
        for (int unsigned i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h11 + i), 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        drive(1'b0, 8'h00, 1'b1);
        for (int unsigned i = 0; i < 4; i++) begin
            chk("t5_burst_v", 32'(f_valid), 32'd1);
            chk("t5_burst_d", 32'(f_data),  32'(8'h11 + i));
            tick();
        end
        chk("t5_drained", 32'(f_empty), 32'd1);
        drive(1'b0, 8'h00, 1'b0);
        tick();

        // 6: reset mid-stream at count 6
        do_reset();
        for (int unsigned i = 0; i < D + 1; i++) begin
            drive(1'b1, 8'($urandom), 1'b0);
            tick();
        end
        for (int unsigned i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        chk("t6_cnt6", 32'(s_count), 32'd6);
`ifdef SYNC_FIFO_STICKY_ERR_EN
        chk("t6_sticky", 32'(s_ovf), 32'd1);
`endif
        do_reset();
        chk("t6_cnt0",  32'(s_count), 32'd0);
        chk("t6_empty", 32'(f_empty), 32'd1);
        chk("t6_full",  32'(s_full),  32'd0);
        chk("t6_valid", 32'(f_valid), 32'd0);
        chk("t6_ovf0",  32'(s_ovf),   32'd0);

        // random traffic, alternating bias toward filling and draining
        for (int unsigned i = 0; i < 400; i++) begin
            bit fill;
            fill = ((i / 50) % 2) == 0;
            drive(($urandom_range(0, 99) < (fill ? 75 : 30)) ? 1'b1 : 1'b0,
                  8'($urandom),
                  ($urandom_range(0, 99) < (fill ? 30 : 75)) ? 1'b1 : 1'b0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
